// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer.
package mux_scan_pkg;

  localparam int unsigned SEL_W_DEF = 4;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } scan_state_t;

endpackage

// File: rtl/mux16x1.sv
// Plain 16:1 single-bit mux scanned by mux_scan_sequencer.
module mux16x1 (
  input  logic [15:0] in,
  input  logic [3:0]  sel,
  output logic        out
);

  assign out = in[sel];

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps an external mux select through all inputs and assembles the sampled bits into a word.
// Optional MUX_SCAN_PARITY_EN adds a registered XOR of the completed word.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int unsigned SEL_W  = SEL_W_DEF,
  parameter int unsigned SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic [SEL_W-1:0]    sel,
  input  logic                mux_out,
  output logic [2**SEL_W-1:0] data,
  output logic                data_valid,
  input  logic                data_ready
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic                parity
`endif
);

  localparam int unsigned N = 2**SEL_W;
  localparam logic [CNT_W-1:0] SettleCnt = CNT_W'(SETTLE);
  localparam logic [SEL_W-1:0] LastSel   = SEL_W'(N - 1);

  scan_state_t      state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     data_q, data_d;
  logic             valid_q, valid_d;
`ifdef MUX_SCAN_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
`ifdef MUX_SCAN_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = '0;
          sel_d   = '0;
          cnt_d   = SettleCnt;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          data_d[sel_q] = mux_out;
          if (sel_q == LastSel) begin
            state_d = HOLD;
            sel_d   = '0;
            valid_d = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
            // Includes the bit captured on this same edge.
            parity_d = ^data_d;
`endif
          end else begin
            sel_d = sel_q + SEL_W'(1);
            cnt_d = SettleCnt;
          end
        end
      end
      HOLD: begin
        if (data_ready) begin
          valid_d = 1'b0;
          if (start) begin
            data_d  = '0;
            cnt_d   = SettleCnt;
            state_d = SCAN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
`ifdef MUX_SCAN_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign busy       = (state_q != IDLE);
  assign sel        = sel_q;
  assign data       = data_q;
  assign data_valid = valid_q;
`ifdef MUX_SCAN_PARITY_EN
  assign parity     = parity_q;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: SETTLE=1 and SETTLE=0 instances, each behind a mux16x1.
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, busy, mux_out, data_valid, data_ready;
  logic [3:0]  sel;
  logic [15:0] data, mux_in;
  logic        start0, busy0, mux_out0, data_valid0, data_ready0;
  logic [3:0]  sel0;
  logic [15:0] data0, mux_in0;
`ifdef MUX_SCAN_PARITY_EN
  logic        parity, parity0;
`endif

  mux16x1 u_mux (.in(mux_in), .sel(sel), .out(mux_out));
  mux16x1 u_mux0 (.in(mux_in0), .sel(sel0), .out(mux_out0));

  mux_scan_sequencer #(.SEL_W(4), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .sel(sel), .mux_out(mux_out),
    .data(data), .data_valid(data_valid), .data_ready(data_ready)
`ifdef MUX_SCAN_PARITY_EN
    , .parity(parity)
`endif
  );

  mux_scan_sequencer #(.SEL_W(4), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .sel(sel0), .mux_out(mux_out0),
    .data(data0), .data_valid(data_valid0), .data_ready(data_ready0)
`ifdef MUX_SCAN_PARITY_EN
    , .parity(parity0)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] word;
    int          hold;
    bit          poke6;
    logic [15:0] exp_data;
    logic        exp_par;
  } vec_t;

  vec_t vecs[5];

  // Called at the negedge after the start edge; counts edges until data_valid.
  task automatic wait_valid(input bit poke6, output int edges, output bit sel_ok);
    edges  = 0;
    sel_ok = 1'b1;
    while (data_valid !== 1'b1 && edges < 100) begin
      if (sel !== 4'(edges / 2)) sel_ok = 1'b0;
      start = (poke6 && sel == 4'd6);
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
  endtask

  task automatic run_scan(input vec_t v);
    int edges;
    bit sel_ok, stable;
    @(negedge clk);
    mux_in = v.word;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    chk("busy_scan", busy, 1);
    wait_valid(v.poke6, edges, sel_ok);
    chk("valid_edges", edges, 32);
    chk("sel_seq", sel_ok, 1);
    chk("data", data, v.exp_data);
`ifdef MUX_SCAN_PARITY_EN
    chk("parity", parity, v.exp_par);
`endif
    stable = 1'b1;
    repeat (v.hold) begin
      @(negedge clk);
      if (data_valid !== 1'b1 || data !== v.exp_data || sel !== 4'd0 || busy !== 1'b1)
        stable = 1'b0;
    end
    chk("hold_stable", stable, 1);
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    chk("post_valid", data_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_data_kept", data, v.exp_data);
  endtask

  initial begin
    int          edges;
    bit          sel_ok;
    logic [15:0] w0[2];
    logic        p0[2];

    vecs[0] = '{word: 16'hA5C3, hold: 5, poke6: 1'b0, exp_data: 16'hA5C3, exp_par: 1'b0};
    vecs[1] = '{word: 16'h1234, hold: 2, poke6: 1'b1, exp_data: 16'h1234, exp_par: 1'b1};
    vecs[2] = '{word: 16'hFFFF, hold: 0, poke6: 1'b0, exp_data: 16'hFFFF, exp_par: 1'b0};
    vecs[3] = '{word: 16'h0000, hold: 1, poke6: 1'b0, exp_data: 16'h0000, exp_par: 1'b0};
    vecs[4] = '{word: 16'h8001, hold: 3, poke6: 1'b0, exp_data: 16'h8001, exp_par: 1'b0};
    w0[0] = 16'h0001; p0[0] = 1'b1;
    w0[1] = 16'h0003; p0[1] = 1'b0;

    rst_n = 1'b0; start = 1'b0; data_ready = 1'b0; mux_in = '0;
    start0 = 1'b0; data_ready0 = 1'b0; mux_in0 = '0;
    repeat (3) @(negedge clk);
    chk("rst_sel", sel, 0);
    chk("rst_data", data, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_scan(vecs[i]);

    // Back-to-back: handshake and restart on the same edge.
    @(negedge clk);
    mux_in = 16'hA5C3;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_valid(1'b0, edges, sel_ok);
    chk("b2b_first_data", data, 16'hA5C3);
    data_ready = 1'b1;
    start      = 1'b1;
    mux_in     = 16'h0F0F;
    @(negedge clk);
    data_ready = 1'b0;
    start      = 1'b0;
    chk("b2b_valid_low", data_valid, 0);
    chk("b2b_busy", busy, 1);
    chk("b2b_data_clr", data, 0);
    wait_valid(1'b0, edges, sel_ok);
    chk("b2b_edges", edges, 32);
    chk("b2b_sel_seq", sel_ok, 1);
    chk("b2b_data", data, 16'h0F0F);
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    chk("b2b_idle", busy, 0);

    // Asynchronous reset mid-scan, between clock edges.
    mux_in = 16'hFFFF;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    edges  = 0;
    while (sel !== 4'd7 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    chk("reached_sel7", sel, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel", sel, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data", data, 0);
    chk("arst_valid", data_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // SETTLE=0: one bit per edge.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mux_in0 = w0[i];
      start0  = 1'b1;
      @(negedge clk);
      start0  = 1'b0;
      edges   = 0;
      while (data_valid0 !== 1'b1 && edges < 100) begin
        @(negedge clk);
        edges++;
      end
      chk("s0_edges", edges, 16);
      chk("s0_data", data0, w0[i]);
`ifdef MUX_SCAN_PARITY_EN
      chk("s0_parity", parity0, p0[i]);
`else
      if (p0[i] !== ^w0[i]) $display("note: parity table inconsistent");
`endif
      data_ready0 = 1'b1;
      @(negedge clk);
      data_ready0 = 1'b0;
      chk("s0_post_valid", data_valid0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
